pipe_reg_skid: RTL and testbench
================================

// Module: pipe_reg_skid
// PURPOSE
//   Parametrised pipeline register: the flow-controlled successor to the plain
//   enable flop. Holds one WIDTH-bit word between pipeline stages with a
//   valid/ready handshake. An optional skid entry keeps full throughput when the
//   downstream stage stalls. Adds flush for branch/exception squash.
//   Used between ALU/processor pipeline stages in place of bare enable registers.
// PARAMETERS
//   WIDTH     32  data width in bits
//   SKID_EN   1   1 = two-entry (main + skid), 1 word/cycle under backpressure;
//                 0 = single entry, in_ready = out_ready | ~out_valid
//   CLR_DATA  1   1 = clr_n also zeroes data regs; 0 = clr_n clears valid bits only
// PORTS
//   clk        in   1      clock; all state changes on posedge
//   clr_n      in   1      reset, synchronous, active-low
//   flush      in   1      synchronous squash of all held entries
//   in_valid   in   1      upstream word present
//   in_ready   out  1      block can accept a word this cycle
//   in_data    in   WIDTH  upstream word
//   out_valid  out  1      out_data holds a valid word
//   out_ready  in   1      downstream accepts a word this cycle
//   out_data   out  WIDTH  held word (the main register)
//   occupancy  out  2      number of held words, 0..2
// BEHAVIOUR
//   - Accept when in_valid & in_ready. Take when out_valid & out_ready. Both are
//     sampled at posedge.
//   - Priority order at posedge:
//       1. clr_n == 0
//       2. flush
//       3. handshakes
//   - Reset (clr_n low at posedge):
//       out_valid = 0, skid valid = 0, occupancy = 0, state = EMPTY.
//       Data regs are zeroed if CLR_DATA = 1, otherwise held.
//       Handshakes in that cycle are ignored.
//   - Outputs are driven straight from registers: out_valid, out_data, occupancy.
//   - in_ready:
//       SKID_EN = 1: in_ready = ~skid_valid (registered; no comb path from out_ready).
//       SKID_EN = 0: in_ready = out_ready | ~out_valid (comb path allowed).
//   - Latency: a word accepted at edge N appears on out_data/out_valid after edge N.
//   - State machine, SKID_EN = 1:
//       EMPTY: accept            -> FULL (main = in_data)
//       FULL:  accept & take     -> FULL (main = in_data)
//              accept & no take  -> SKID (skid = in_data, main held)
//              take & no accept  -> EMPTY
//              neither           -> FULL
//       SKID:  take              -> FULL (main = skid); no accept possible (in_ready = 0)
//              no take           -> SKID, all held
//   - SKID_EN = 0: only EMPTY and FULL exist; the SKID transitions never occur.
//   - Ordering: words leave in arrival order; no word is ever dropped or duplicated
//     outside flush or reset.
//   - flush (clr_n high): next state is EMPTY. Any word accepted in the same cycle
//     is discarded; a take in the same cycle still counts as consumed downstream.
//     Data regs are unchanged.
//   - occupancy: EMPTY = 0, FULL = 1, SKID = 2.
//   - No X on out_data after the first reset when CLR_DATA = 1.
// TESTING
//   1. Reset: clr_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0,
//      occupancy = 0, out_data = 0 (CLR_DATA = 1).
//   2. Streaming: out_ready = 1, send 0x11, 0x22, 0x33 back-to-back -> out_data
//      shows 0x11, 0x22, 0x33 on consecutive cycles, one cycle after each accept;
//      in_ready stays 1.
//   3. Stall: out_ready = 0, send 0xA, 0xB -> occupancy = 2, in_ready = 0.
//      Then out_ready = 1 -> out 0xA, then 0xB; occupancy 2 -> 1 -> 0.
//   4. Flush: with occupancy = 2, pulse flush together with in_valid = 1 and
//      in_data = 0xC -> next cycle out_valid = 0, occupancy = 0, 0xC never emitted.
//   5. Mid-stall reset: occupancy = 2, pull clr_n low for 1 cycle -> occupancy = 0,
//      in_ready = 1; the next accepted 0x5 is the first word out.
//   6. SKID_EN = 0 build: out_valid = 1, out_ready = 0 -> in_ready = 0; with
//      out_ready = 1 and in_valid = 1 -> 1 word/cycle, occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: flow-controlled pipeline register with an optional skid entry.
//
// Holds up to two words between pipeline stages using a valid/ready handshake.
// With SKID_EN = 1, in_ready comes straight from a flop, so there is no
// combinational path from out_ready to in_ready, and the stage still moves one
// word per cycle under backpressure. With SKID_EN = 0 the block is a single
// entry, and in_ready may follow out_ready combinationally.
// flush squashes every held word. It also discards a word accepted in the same
// cycle. clr_n is a synchronous, active-low reset and takes priority over flush.

module pipe_reg_skid #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SKID_EN  = 1'b1,
  parameter bit          CLR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // EMPTY holds no word. FULL holds one word in main. SKID holds two words:
  // the older one in main and the newer one in skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic [1:0]       occ_q;

  logic             accept;
  logic             take;

  // Gives the word count that each state presents on occupancy.
  function automatic logic [1:0] occ_of(input state_e s);
    case (s)
      ST_FULL: return 2'd1;
      ST_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  assign accept = in_valid & in_ready;
  assign take   = out_valid_q & out_ready;

  // Builds in_ready. The skid build uses only a flop. The single-entry build may
  // accept a new word in the same cycle that it hands its current word out.
  if (SKID_EN) begin : g_ready_skid
    assign in_ready = ~skid_valid_q;
  end else begin : g_ready_single
    assign in_ready = out_ready | ~out_valid_q;
  end

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  // Next-state and data-steering logic. The handshakes are decided first, and a
  // flush then overrides them.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred. Blocking '=' is
    // correct here because this is combinational logic, not state.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end
      end
      ST_FULL: begin
        if (accept && take) begin
          main_d = in_data;
        end else if (accept && SKID_EN) begin
          // The older word stays in main so that words leave in arrival order.
          state_d = ST_SKID;
          skid_d  = in_data;
        end else if (take) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only a take can happen.
        if (take) begin
          state_d = ST_FULL;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // A squash drops every held word and any word that arrives with it. The
    // data registers keep their old contents, and out_valid low marks them stale.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Control state. The state and the registered flags that drive the outputs
  // all update together from state_d.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=', so every flop samples the
    // values from before the edge, whatever order the statements are in.
    if (!clr_n) begin
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= (state_d != ST_EMPTY);
      skid_valid_q <= (state_d == ST_SKID);
      occ_q        <= occ_of(state_d);
    end
  end

  // Data registers. Reset clears them only when CLR_DATA is set.
  always_ff @(posedge clk) begin
    // NOTE: the valid flags alone decide whether data is meaningful. Clearing
    // the data registers on reset only keeps out_data free of X, so with
    // CLR_DATA = 0 the data flops are left without a reset.
    if (!clr_n) begin
      if (CLR_DATA) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed vectors for the skid build, plus hand-written
// sequences for arrival order under backpressure and for the single-entry build.

module tb_pipe_reg_skid;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Skid build, SKID_EN = 1 and CLR_DATA = 1.
  logic         s_clr_n, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [W-1:0] s_in_data, s_out_data;
  logic [1:0]   s_occ;

  // Single-entry build, SKID_EN = 0 and CLR_DATA = 1.
  logic         n_clr_n, n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [W-1:0] n_in_data, n_out_data;
  logic [1:0]   n_occ;

  pipe_reg_skid #(.WIDTH(W), .SKID_EN(1'b1), .CLR_DATA(1'b1)) u_skid (
    .clk      (clk),
    .clr_n    (s_clr_n),
    .flush    (s_flush),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_data (s_out_data),
    .occupancy(s_occ)
  );

  pipe_reg_skid #(.WIDTH(W), .SKID_EN(1'b0), .CLR_DATA(1'b1)) u_single (
    .clk      (clk),
    .clr_n    (n_clr_n),
    .flush    (n_flush),
    .in_valid (n_in_valid),
    .in_ready (n_in_ready),
    .in_data  (n_in_data),
    .out_valid(n_out_valid),
    .out_ready(n_out_ready),
    .out_data (n_out_data),
    .occupancy(n_occ)
  );

  typedef struct {
    logic         clr_n;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic [1:0]   exp_occ;
    logic         exp_ready;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic f, input logic iv, input logic [W-1:0] d,
                              input logic orr, input logic ev, input logic [W-1:0] ed,
                              input logic [1:0] eo, input logic er);
    vec_t v;
    v.clr_n = c;   v.flush = f;      v.in_valid = iv; v.in_data = d; v.out_ready = orr;
    v.exp_valid = ev; v.exp_data = ed; v.exp_occ = eo; v.exp_ready = er;
    return v;
  endfunction

  initial begin
    int   sent;
    int   rcvd;
    int   cyc;
    logic acc;
    logic tk;
    logic [W-1:0] td;

    // Each vector gives the inputs held across one posedge and the outputs
    // expected just after that edge:
    //        clr fl  iv  data       ordy | valid data       occ  rdy
    vecs[0]  = mk(0, 0, 1, 32'h99, 0,     0, 32'h00, 2'd0, 1);  // reset, in_valid ignored
    vecs[1]  = mk(0, 0, 1, 32'h99, 0,     0, 32'h00, 2'd0, 1);
    vecs[2]  = mk(1, 0, 1, 32'h11, 1,     1, 32'h11, 2'd1, 1);  // streaming
    vecs[3]  = mk(1, 0, 1, 32'h22, 1,     1, 32'h22, 2'd1, 1);
    vecs[4]  = mk(1, 0, 1, 32'h33, 1,     1, 32'h33, 2'd1, 1);
    vecs[5]  = mk(1, 0, 0, 32'h00, 1,     0, 32'h33, 2'd0, 1);  // drain
    vecs[6]  = mk(1, 0, 1, 32'h0A, 0,     1, 32'h0A, 2'd1, 1);  // stall
    vecs[7]  = mk(1, 0, 1, 32'h0B, 0,     1, 32'h0A, 2'd2, 0);  // skid fills
    vecs[8]  = mk(1, 0, 1, 32'hEE, 0,     1, 32'h0A, 2'd2, 0);  // not accepted
    vecs[9]  = mk(1, 0, 0, 32'h00, 1,     1, 32'h0B, 2'd1, 1);
    vecs[10] = mk(1, 0, 0, 32'h00, 1,     0, 32'h0B, 2'd0, 1);
    vecs[11] = mk(1, 0, 1, 32'h01, 0,     1, 32'h01, 2'd1, 1);
    vecs[12] = mk(1, 0, 1, 32'h02, 0,     1, 32'h01, 2'd2, 0);
    vecs[13] = mk(1, 1, 1, 32'h0C, 0,     0, 32'h01, 2'd0, 1);  // flush from SKID
    vecs[14] = mk(1, 0, 1, 32'h03, 0,     1, 32'h03, 2'd1, 1);
    vecs[15] = mk(1, 1, 1, 32'h0C, 1,     0, 32'h03, 2'd0, 1);  // flush + take + accept
    vecs[16] = mk(1, 0, 0, 32'h00, 1,     0, 32'h03, 2'd0, 1);  // 0xC never shows
    vecs[17] = mk(1, 0, 1, 32'h07, 0,     1, 32'h07, 2'd1, 1);
    vecs[18] = mk(1, 0, 1, 32'h08, 0,     1, 32'h07, 2'd2, 0);
    vecs[19] = mk(0, 0, 0, 32'h00, 0,     0, 32'h00, 2'd0, 1);  // reset during stall
    vecs[20] = mk(1, 0, 1, 32'h05, 1,     1, 32'h05, 2'd1, 1);  // first word out is 0x5
    vecs[21] = mk(1, 0, 0, 32'h00, 1,     0, 32'h05, 2'd0, 1);
    vecs[22] = mk(1, 0, 1, 32'h40, 0,     1, 32'h40, 2'd1, 1);
    vecs[23] = mk(1, 0, 0, 32'h00, 0,     1, 32'h40, 2'd1, 1);  // FULL, neither
    vecs[24] = mk(1, 0, 0, 32'h00, 1,     0, 32'h40, 2'd0, 1);

    s_clr_n = 1'b0; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    n_clr_n = 1'b0; n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;

    // Table-driven vectors on the skid build.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      s_clr_n     = vecs[i].clr_n;
      s_flush     = vecs[i].flush;
      s_in_valid  = vecs[i].in_valid;
      s_in_data   = vecs[i].in_data;
      s_out_ready = vecs[i].out_ready;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), W'(s_out_valid), W'(vecs[i].exp_valid));
      check($sformatf("v%0d out_data", i),  s_out_data,      vecs[i].exp_data);
      check($sformatf("v%0d occupancy", i), W'(s_occ),       W'(vecs[i].exp_occ));
      check($sformatf("v%0d in_ready", i),  W'(s_in_ready),  W'(vecs[i].exp_ready));
    end

    // Arrival order under periodic backpressure. Words 1..20 must leave in order.
    sent = 1;
    rcvd = 1;
    cyc  = 0;
    while (rcvd <= 20 && cyc < 300) begin
      @(negedge clk);
      s_clr_n     = 1'b1;
      s_flush     = 1'b0;
      s_in_valid  = (sent <= 20);
      s_in_data   = W'(sent);
      s_out_ready = ((cyc % 3) != 2);
      #1;
      acc = s_in_valid & s_in_ready;
      tk  = s_out_valid & s_out_ready;
      td  = s_out_data;
      @(posedge clk);
      if (tk) begin
        check("order", td, W'(rcvd));
        rcvd++;
      end
      if (acc) sent++;
      cyc++;
    end
    if (rcvd <= 20) check("order timeout", W'(rcvd), W'(21));
    @(negedge clk);
    s_in_valid = 1'b0;

    // Single-entry build: reset with in_valid high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_clr_n = 1'b0; n_in_valid = 1'b1; n_in_data = 32'h77; n_out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("ns reset out_valid", W'(n_out_valid), W'(0));
      check("ns reset occupancy", W'(n_occ), W'(0));
      check("ns reset out_data", n_out_data, W'(0));
    end

    // Fill the single entry with the downstream stalled.
    @(negedge clk);
    n_clr_n = 1'b1; n_in_valid = 1'b1; n_in_data = 32'h21; n_out_ready = 1'b0;
    #1;
    check("ns ready when empty", W'(n_in_ready), W'(1));
    @(posedge clk);
    #1;
    check("ns fill out_valid", W'(n_out_valid), W'(1));
    check("ns fill out_data", n_out_data, W'(32'h21));
    check("ns stall in_ready", W'(n_in_ready), W'(0));

    // A stalled full entry must refuse a new word.
    @(negedge clk);
    n_in_data = 32'h99;
    @(posedge clk);
    #1;
    check("ns hold out_data", n_out_data, W'(32'h21));
    check("ns hold occupancy", W'(n_occ), W'(1));

    // With out_ready high it streams one word per cycle and stays at one entry.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_out_ready = 1'b1; n_in_valid = 1'b1; n_in_data = W'(32'h31 + k);
      #1;
      check($sformatf("ns stream%0d in_ready", k), W'(n_in_ready), W'(1));
      @(posedge clk);
      #1;
      check($sformatf("ns stream%0d out_data", k), n_out_data, W'(32'h31 + k));
      check($sformatf("ns stream%0d occupancy", k), W'(n_occ), W'(1));
    end

    @(negedge clk);
    n_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ns drain out_valid", W'(n_out_valid), W'(0));
    check("ns drain occupancy", W'(n_occ), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
